muldiv_ctrl: RTL

Sequencer for the multi-cycle `mult` unit and its companion divider. It accepts mult/div requests from CPU control, launches the start pulse, and counts the fixed latency. It then commits the results into the architectural HI/LO registers. It stalls the pipeline on any HI/LO access or new request while an operation is in flight, and it services mthi/mtlo writes.

---
 rtl/muldiv_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle multiplier/divider: operand capture, start pulse, latency count, HI/LO commit.
// Optional build macro DIV_ZERO_TRAP_EN: a divide with srcB == 0 is trapped in IDLE and flagged on divZero.
module muldiv_ctrl #(
    parameter int unsigned N           = 32,
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] srcA,
    input  logic [N-1:0] srcB,
    input  logic         multOp,
    input  logic         divOp,
    input  logic         hiRead,
    input  logic         loRead,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [N-1:0] writeData,
    input  logic [N-1:0] multHi,
    input  logic [N-1:0] multLo,
    input  logic [N-1:0] divHi,
    input  logic [N-1:0] divLo,
    output logic [N-1:0] opA,
    output logic [N-1:0] opB,
    output logic         multCtrl,
    output logic         divCtrl,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic         divZero
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] MSTART = 3'd1;
    localparam logic [2:0] MRUN   = 3'd2;
    localparam logic [2:0] DSTART = 3'd3;
    localparam logic [2:0] DRUN   = 3'd4;
    localparam logic [2:0] COMMIT = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             op_div;
    logic             op_div_nxt;
    logic [N-1:0]     hi_nxt;
    logic [N-1:0]     lo_nxt;
    logic [N-1:0]     opA_nxt;
    logic [N-1:0]     opB_nxt;
    logic             done_nxt;
    logic             trap_c;

`ifdef DIV_ZERO_TRAP_EN
    logic zero_nxt;

    assign trap_c   = (srcB == '0);
    assign zero_nxt = (state == IDLE) && !multOp && divOp && trap_c;

    // Trap flag pulses in the cycle after a trapped divide is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            divZero <= 1'b0;
        end else begin
            divZero <= zero_nxt;
        end
    end
`else
    assign trap_c  = 1'b0;
    assign divZero = 1'b0;
`endif

    assign busy     = (state != IDLE);
    assign stall    = busy && (hiRead || loRead || multOp || divOp || mthi || mtlo);
    assign multCtrl = (state == MSTART);
    assign divCtrl  = (state == DSTART);

    // Next-state, counter and HI/LO update
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        op_div_nxt = op_div;
        hi_nxt     = hi;
        lo_nxt     = lo;
        opA_nxt    = opA;
        opB_nxt    = opB;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (mthi) hi_nxt = writeData;
                if (mtlo) lo_nxt = writeData;
                if (multOp) begin
                    opA_nxt   = srcA;
                    opB_nxt   = srcB;
                    state_nxt = MSTART;
                end else if (divOp) begin
                    opA_nxt = srcA;
                    opB_nxt = srcB;
                    if (trap_c) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = DSTART;
                    end
                end
            end
            MSTART: begin
                cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
                state_nxt = MRUN;
            end
            DSTART: begin
                cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                state_nxt = DRUN;
            end
            MRUN, DRUN: begin
                if (cnt == '0) begin
                    op_div_nxt = (state == DRUN);
                    state_nxt  = COMMIT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            COMMIT: begin
                hi_nxt    = op_div ? divHi : multHi;
                lo_nxt    = op_div ? divLo : multLo;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset mid-operation drops the op without a commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            opA    <= '0;
            opB    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_div <= op_div_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            opA    <= opA_nxt;
            opB    <= opB_nxt;
            done   <= done_nxt;
        end
    end

endmodule
